// File: rtl/dt_walk_engine.sv
// rtl/dt_walk_engine.sv - table-driven decision-tree walker, one node per clock
// Node word layout, MSB first: {leaf, feat, child_t, child_f, cls}.
module dt_walk_engine #(
   parameter int N_FEAT      = 12,
   parameter int CLS_W       = 3,
   parameter int N_NODES     = 256,
   parameter int MAX_DEPTH   = 16,
   parameter int DEFAULT_CLS = 0,
   localparam int NODE_W     = $clog2(N_NODES),
   localparam int FIDX_W     = $clog2(N_FEAT),
   localparam int WORD_W     = 1 + FIDX_W + 2*NODE_W + CLS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [NODE_W-1:0] cfg_addr,
   input  logic [WORD_W-1:0] cfg_wdata,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_FEAT-1:0] inp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CLS_W-1:0]  outp,
   output logic              out_err,
   output logic              busy
);

   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   node_mem [N_NODES];
   logic [NODE_W-1:0]   ptr_q;
   logic [DEPTH_W-1:0]  depth_q;
   logic [N_FEAT-1:0]   inp_q;

   logic [WORD_W-1:0]   node;
   logic                n_leaf;
   logic [FIDX_W-1:0]   n_feat;
   logic [NODE_W-1:0]   n_child_t;
   logic [NODE_W-1:0]   n_child_f;
   logic [CLS_W-1:0]    n_cls;
   logic                abort;

   assign node      = node_mem[ptr_q];
   assign n_leaf    = node[WORD_W-1];
   assign n_feat    = node[WORD_W-2 -: FIDX_W];
   assign n_child_t = node[CLS_W+NODE_W +: NODE_W];
   assign n_child_f = node[CLS_W +: NODE_W];
   assign n_cls     = node[CLS_W-1:0];

   // Out-of-range feature index or runaway path (loops) both end the walk as an error.
   assign abort = (32'(n_feat) >= N_FEAT) || (depth_q == DEPTH_W'(MAX_DEPTH));

   assign in_ready = (state_q == IDLE);
   assign busy     = !in_ready;

   // Table is deliberately outside the reset domain so a trained model survives rst.
   always_ff @(posedge clk) begin
      if (cfg_we && state_q == IDLE)
         node_mem[cfg_addr] <= cfg_wdata;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = WALK;
         WALK:    if (n_leaf || abort) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         out_valid <= 1'b0;
         outp      <= '0;
         out_err   <= 1'b0;
         ptr_q     <= '0;
         depth_q   <= '0;
         inp_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  inp_q   <= inp;
                  ptr_q   <= '0;
                  depth_q <= '0;
               end
            end
            WALK: begin
               if (n_leaf) begin
                  outp      <= n_cls;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
               end else if (abort) begin
                  outp      <= CLS_W'(DEFAULT_CLS);
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
               end else begin
                  ptr_q   <= inp_q[n_feat] ? n_child_t : n_child_f;
                  depth_q <= depth_q + DEPTH_W'(1);
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dt_walk_engine.sv
// tb/tb_dt_walk_engine.sv - self-checking bench for dt_walk_engine
module tb_dt_walk_engine;

   localparam int N_FEAT = 12, CLS_W = 3, N_NODES = 256, MAX_DEPTH = 16, DEFAULT_CLS = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [7:0]  cfg_addr;
   logic [23:0] cfg_wdata;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] inp;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  outp;
   logic        out_err;
   logic        busy;

   always #5 clk = ~clk;

   dt_walk_engine #(
      .N_FEAT(N_FEAT), .CLS_W(CLS_W), .N_NODES(N_NODES),
      .MAX_DEPTH(MAX_DEPTH), .DEFAULT_CLS(DEFAULT_CLS)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
      .out_valid(out_valid), .out_ready(out_ready),
      .outp(outp), .out_err(out_err), .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0] cls;
      logic       err;
      int         lat;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int         tree;
      logic [11:0] v;
      logic [2:0] cls;
      logic       err;
      int         lat;
   } vec_t;
   vec_t vt[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] mk(input logic leaf, input logic [3:0] feat,
                                      input logic [7:0] t, input logic [7:0] f,
                                      input logic [2:0] cls);
      return {leaf, feat, t, f, cls};
   endfunction

   task automatic wr(input logic [7:0] a, input logic [23:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic load_tree0();
      wr(8'd0, mk(1'b0, 4'd2, 8'd1, 8'd2, 3'd0));
      wr(8'd1, mk(1'b1, 4'd0, 8'd0, 8'd0, 3'b011));
      wr(8'd2, mk(1'b1, 4'd0, 8'd0, 8'd0, 3'b111));
   endtask

   task automatic load_tree1();
      wr(8'd2, mk(1'b0, 4'd11, 8'd5, 8'd6, 3'd0));
      wr(8'd5, mk(1'b1, 4'd0,  8'd0, 8'd0, 3'd4));
      wr(8'd6, mk(1'b0, 4'd0,  8'd7, 8'd8, 3'd0));
      wr(8'd7, mk(1'b1, 4'd0,  8'd0, 8'd0, 3'd6));
      wr(8'd8, mk(1'b0, 4'd13, 8'd0, 8'd0, 3'd5));
   endtask

   // cw_mode: 0 no write, 1 write on the accept edge, 2 write during the first walk cycle
   task automatic query(input string tag, input logic [11:0] v, input logic [2:0] cls,
                        input logic err, input int lat, input int hold, input int cw_mode,
                        input logic [7:0] cw_addr, input logic [23:0] cw_data);
      exp_t e;
      int   cyc;
      @(negedge clk);
      in_valid = 1'b1; inp = v;
      if (cw_mode == 1) begin cfg_we = 1'b1; cfg_addr = cw_addr; cfg_wdata = cw_data; end
      chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      sb.push_back(exp_t'{cls, err, lat});
      @(posedge clk); #1;
      in_valid = 1'b0; inp = 12'($urandom); cfg_we = 1'b0;
      if (cw_mode == 2) begin cfg_we = 1'b1; cfg_addr = cw_addr; cfg_wdata = cw_data; end
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         cfg_we = 1'b0;
      end
      cfg_we = 1'b0;
      if (!out_valid) begin
         chk({tag, "/timeout"}, 32'(out_valid), 32'd1);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      chk({tag, "/latency"}, 32'(cyc), 32'(e.lat));
      chk({tag, "/outp"}, 32'(outp), 32'(e.cls));
      chk({tag, "/out_err"}, 32'(out_err), 32'(e.err));
      chk({tag, "/busy"}, 32'(busy), 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = 1'b1; inp = ~v;
         @(posedge clk); #1;
         chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "/hold_outp"}, 32'(outp), 32'(e.cls));
         chk({tag, "/hold_err"}, 32'(out_err), 32'(e.err));
         chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "/post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "/post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cur_tree;
      vt[0]  = '{0, 12'h004, 3'b011, 1'b0, 2};
      vt[1]  = '{0, 12'h000, 3'b111, 1'b0, 2};
      vt[2]  = '{0, 12'hFFF, 3'b011, 1'b0, 2};
      vt[3]  = '{0, 12'hFFB, 3'b111, 1'b0, 2};
      vt[4]  = '{1, 12'h800, 3'd4,   1'b0, 3};
      vt[5]  = '{1, 12'h001, 3'd6,   1'b0, 4};
      vt[6]  = '{1, 12'h000, 3'd0,   1'b1, 4};
      vt[7]  = '{1, 12'hFFB, 3'd4,   1'b0, 3};
      vt[8]  = '{1, 12'h0FD, 3'b011, 1'b0, 2};
      vt[9]  = '{1, 12'h7FA, 3'd0,   1'b1, 4};
      vt[10] = '{1, 12'h003, 3'd6,   1'b0, 4};

      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      in_valid = 1'b0; inp = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset/in_ready", 32'(in_ready), 32'd1);
      chk("reset/out_valid", 32'(out_valid), 32'd0);
      chk("reset/outp", 32'(outp), 32'd0);
      chk("reset/out_err", 32'(out_err), 32'd0);
      chk("reset/busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      load_tree0();
      cur_tree = 0;
      for (int i = 0; i < 11; i++) begin
         if (vt[i].tree != cur_tree) begin
            load_tree1();
            cur_tree = vt[i].tree;
         end
         query($sformatf("vec%0d", i), vt[i].v, vt[i].cls, vt[i].err, vt[i].lat, 0, 0, 8'd0, 24'd0);
      end

      // write to node1 during the walk is dropped; the follow-up query proves node1 is untouched
      query("walk_wr", 12'h004, 3'b011, 1'b0, 2, 0, 2, 8'd1, mk(1'b1, 4'd0, 8'd0, 8'd0, 3'd2));
      query("walk_wr_after", 12'h004, 3'b011, 1'b0, 2, 0, 0, 8'd0, 24'd0);

      // reset mid-walk, then re-issue against the retained table
      @(negedge clk);
      in_valid = 1'b1; inp = 12'h001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid/busy_before", 32'(busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid/out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid/in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid/no_stale", 32'(out_valid), 32'd0);
      query("rst_reissue", 12'h001, 3'd6, 1'b0, 4, 0, 0, 8'd0, 24'd0);

      query("backpressure", 12'h800, 3'd4, 1'b0, 3, 5, 0, 8'd0, 24'd0);
      @(posedge clk); #1;
      chk("backpressure/no_second", 32'(out_valid), 32'd0);

      // root rewritten to a leaf on the accept edge; the walk must see it
      query("root_leaf_acc", 12'h004, 3'd5, 1'b0, 1, 0, 1, 8'd0, mk(1'b1, 4'd0, 8'd0, 8'd0, 3'd5));
      query("root_leaf", 12'h000, 3'd5, 1'b0, 1, 0, 0, 8'd0, 24'd0);

      wr(8'd0, mk(1'b0, 4'd0, 8'd0, 8'd0, 3'd3));
      query("self_loop", 12'hFFF, 3'(DEFAULT_CLS), 1'b1, MAX_DEPTH + 1, 0, 0, 8'd0, 24'd0);

      wr(8'd0, mk(1'b0, 4'd13, 8'd1, 8'd1, 3'd5));
      query("bad_feat", 12'h000, 3'(DEFAULT_CLS), 1'b1, 1, 0, 0, 8'd0, 24'd0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
